// File: rtl/idli_res_m.sv
// idli_res_m: serial result collector.
// Gathers LSN-first ALU nibbles into a 4*NIBBLES result with carry and zero
// flags, then holds it for a valid/ready handshake with writeback. While an
// unaccepted result is held, o_res_busy stalls the upstream serial pipeline.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting nibbles, cnt = nibbles gathered for current result
// FULL    | result held on o_res_*, waiting for i_res_rdy
module idli_res_m #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_res_gck,
    input  logic                 i_res_rst_n,
    input  logic                 i_res_nib_vld,
    input  logic [3:0]           i_res_nib,
    input  logic                 i_res_cout,
    input  logic                 i_res_ctr_last_cycle,
    input  logic                 i_res_rdy,
    output logic                 o_res_vld,
    output logic [4*NIBBLES-1:0] o_res_data,
    output logic                 o_res_carry,
    output logic                 o_res_zero,
    output logic                 o_res_busy,
    output logic                 o_res_err
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            acc_nz;
    logic [W-1:0]    sreg;
    logic [W-1:0]    sreg_nxt;
    logic            accept;
    logic            cnt_last;
    logic            handshake;

    // Stall is the only combinational input-to-output path.
    assign o_res_busy = (state == FULL) && !i_res_rdy;
    assign accept     = i_res_nib_vld && !o_res_busy;
    assign cnt_last   = (cnt == CNT_LAST);
    assign handshake  = (state == FULL) && i_res_rdy;

    // New nibble enters at the top so the first nibble ends up in bits [3:0].
    generate
        if (NIBBLES == 1) begin : g_one
            assign sreg_nxt = i_res_nib;
        end else begin : g_many
            assign sreg_nxt = {i_res_nib, sreg[W-1:4]};
        end
    endgenerate

    // Collection/hold sequencing with registered result outputs.
    always_ff @(posedge i_res_gck) begin
        if (!i_res_rst_n) begin
            state       <= COLLECT;
            cnt         <= '0;
            acc_nz      <= 1'b0;
            sreg        <= '0;
            o_res_vld   <= 1'b0;
            o_res_data  <= '0;
            o_res_carry <= 1'b0;
            o_res_zero  <= 1'b1;
            o_res_err   <= 1'b0;
        end else begin
            // Release the held result; a nibble accepted this same cycle
            // (handled below) becomes nibble 0 of the next result.
            if (handshake) begin
                state     <= COLLECT;
                o_res_vld <= 1'b0;
            end
            if (accept) begin
                if (i_res_ctr_last_cycle && cnt_last) begin
                    o_res_data  <= sreg_nxt;
                    o_res_carry <= i_res_cout;
                    o_res_zero  <= ~(acc_nz | (|i_res_nib));
                    o_res_vld   <= 1'b1;
                    state       <= FULL;
                    cnt         <= '0;
                    acc_nz      <= 1'b0;
                    sreg        <= '0;
                end else if (i_res_ctr_last_cycle || cnt_last) begin
                    // Framing error: early last marker or missing one.
                    o_res_err <= 1'b1;
                    cnt       <= '0;
                    acc_nz    <= 1'b0;
                    sreg      <= '0;
                end else begin
                    cnt    <= cnt + CW'(1);
                    acc_nz <= acc_nz | (|i_res_nib);
                    sreg   <= sreg_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_idli_res_m.sv
// Self-checking bench for idli_res_m: directed vector table, hand-written
// hold/reset sequences and random traffic against a queue-based model.
module tb_idli_res_m;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nib_vld = 1'b0;
    logic [3:0]  nib = '0;
    logic        cout = 1'b0;
    logic        last = 1'b0;
    logic        rdy = 1'b0;
    logic        res_vld;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic        res_busy;
    logic        res_err;

    int n_tests = 0;
    int n_fail  = 0;

    idli_res_m #(.NIBBLES(N)) dut (
        .i_res_gck            (clk),
        .i_res_rst_n          (rst_n),
        .i_res_nib_vld        (nib_vld),
        .i_res_nib            (nib),
        .i_res_cout           (cout),
        .i_res_ctr_last_cycle (last),
        .i_res_rdy            (rdy),
        .o_res_vld            (res_vld),
        .o_res_data           (res_data),
        .o_res_carry          (res_carry),
        .o_res_zero           (res_zero),
        .o_res_busy           (res_busy),
        .o_res_err            (res_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: list of accepted nibbles, result computed by arithmetic.
    logic [3:0]  m_q[$];
    bit          m_full;
    logic [15:0] m_data;
    logic        m_carry;
    logic        m_zero;
    logic        m_err;

    task automatic m_reset();
        m_q.delete();
        m_full  = 0;
        m_data  = '0;
        m_carry = 1'b0;
        m_zero  = 1'b1;
        m_err   = 1'b0;
    endtask

    task automatic m_edge(input logic r, input logic v, input logic [3:0] n,
                          input logic c, input logic l, input logic rd);
        bit acc;
        int sum;
        if (!r) begin
            m_reset();
            return;
        end
        acc = v && !(m_full && !rd);
        if (m_full && rd) m_full = 0;
        if (acc) begin
            m_q.push_back(n);
            if (m_q.size() == N && l) begin
                sum = 0;
                foreach (m_q[i]) sum += int'(m_q[i]) * (1 << (4 * i));
                m_data  = 16'(sum);
                m_zero  = (sum == 0);
                m_carry = c;
                m_full  = 1;
                m_q.delete();
            end else if (l || m_q.size() == N) begin
                m_err = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs driven after negedge, busy checked pre-edge,
    // registered outputs checked 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] n,
                         input logic c, input logic l, input logic rd);
        rst_n = r; nib_vld = v; nib = n; cout = c; last = l; rdy = rd;
        #1;
        chk("busy", res_busy, (m_full && !rd) ? 1 : 0);
        @(posedge clk);
        m_edge(r, v, n, c, l, rd);
        #1;
        chk("vld",   res_vld,   m_full ? 1 : 0);
        chk("data",  res_data,  m_data);
        chk("carry", res_carry, m_carry);
        chk("zero",  res_zero,  m_zero);
        chk("err",   res_err,   m_err);
        @(negedge clk);
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  n;
        logic        c;
        logic        l;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_carry;
        logic        e_zero;
        logic        e_err;
    } vec_t;

    vec_t tbl[26];

    initial begin
        tbl = '{
            // 0x4,0x3,0x2,0x1 -> 0x1234 carry 1
            '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
            '{1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0},
            // all-zero result, final carry 1
            '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0},
            '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0},
            '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0},
            '{1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0},
            // back-to-back 0xF..0x8 -> 0xCDEF, 0x89AB without stall
            '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0},
            '{1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0},
            '{1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0},
            '{1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 16'hCDEF, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 16'hCDEF, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 16'hCDEF, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 16'hCDEF, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 16'h89AB, 1'b0, 1'b0, 1'b0},
            '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h89AB, 1'b0, 1'b0, 1'b0},
            // early last -> sticky err, then clean 0x0001
            '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'h89AB, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h89AB, 1'b0, 1'b0, 1'b1},
            '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'h89AB, 1'b0, 1'b0, 1'b1},
            '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h89AB, 1'b0, 1'b0, 1'b1},
            '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h89AB, 1'b0, 1'b0, 1'b1},
            '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1},
            '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1}
        };

        m_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Directed vector table
        for (int i = 0; i < 26; i++) begin
            drive(1'b1, tbl[i].v, tbl[i].n, tbl[i].c, tbl[i].l, 1'b1);
            chk($sformatf("tbl%0d_vld", i),   res_vld,   tbl[i].e_vld);
            chk($sformatf("tbl%0d_data", i),  res_data,  tbl[i].e_data);
            chk($sformatf("tbl%0d_carry", i), res_carry, tbl[i].e_carry);
            chk($sformatf("tbl%0d_zero", i),  res_zero,  tbl[i].e_zero);
            chk($sformatf("tbl%0d_err", i),   res_err,   tbl[i].e_err);
        end

        // Reset while FULL: everything back to reset values
        drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);
        chk("full_before_rst", res_vld, 1);
        drive(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        chk("rst_vld", res_vld, 0);
        chk("rst_data", res_data, 16'h0000);
        chk("rst_zero", res_zero, 1);
        chk("rst_err", res_err, 0);
        #1 chk("rst_busy", res_busy, 0);

        // Hold with rdy=0 for 3 cycles while 0xA is presented
        drive(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
            chk("hold_vld", res_vld, 1);
            chk("hold_data", res_data, 16'h4321);
        end
        drive(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
        chk("hs_vld", res_vld, 0);
        drive(1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'hD, 1'b1, 1'b1, 1'b1);
        chk("after_hold_data", res_data, 16'hDCBA);
        chk("after_hold_vld", res_vld, 1);

        // Reset mid-collection, then clean 0x5,0x6,0x7,0x8
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_data", res_data, 16'h8765);
        chk("mid_rst_err", res_err, 0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic r, v, c, l, rd;
            logic [3:0] n;
            r  = ($urandom_range(0, 149) != 0);
            v  = ($urandom_range(0, 3) != 0);
            n  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            c  = 1'($urandom_range(0, 1));
            l  = (m_q.size() == N - 1) ? ($urandom_range(0, 7) != 0)
                                       : ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 2) != 0);
            drive(r, v, n, c, l, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
